// File: rtl/dma_desc_sequencer.sv
// rtl/dma_desc_sequencer.sv - descriptor-driven DMA register programmer
// Per descriptor: SRC/DST/LEN/START single-beat writes, wait for done, one status word.
module dma_desc_sequencer #(
  parameter logic [43:0] REG_SRC        = 44'h000,
  parameter logic [43:0] REG_DST        = 44'h080,
  parameter logic [43:0] REG_LEN        = 44'h100,
  parameter logic [43:0] REG_START      = 44'h180,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic         clk,
  input  logic         rst_bar,
  input  logic [103:0] desc_dat,
  input  logic         desc_vld,
  output logic         desc_rdy,
  output logic [43:0]  m_aw_dat,
  output logic         m_aw_vld,
  input  logic         m_aw_rdy,
  output logic [72:0]  m_w_dat,
  output logic         m_w_vld,
  input  logic         m_w_rdy,
  input  logic [5:0]   m_b_dat,
  input  logic         m_b_vld,
  output logic         m_b_rdy,
  input  logic         dma_done_dat,
  input  logic         dma_done_vld,
  output logic         dma_done_rdy,
  output logic [9:0]   stat_dat,
  output logic         stat_vld,
  input  logic         stat_rdy,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_WAIT_DONE,
    S_REPORT
  } state_t;

  localparam logic [1:0] CODE_OK      = 2'd0;
  localparam logic [1:0] CODE_BRESP   = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT = 2'd2;
  localparam logic [1:0] CODE_SKIP    = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  ri_q, ri_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic [7:0]  tag_q, tag_d;
  logic [1:0]  code_q, code_d;

  logic        desc_rdy_q;
  logic        m_aw_vld_q;
  logic [43:0] m_aw_dat_q;
  logic        m_w_vld_q;
  logic [72:0] m_w_dat_q;
  logic        m_b_rdy_q;
  logic        dma_done_rdy_q;
  logic        stat_vld_q;
  logic [9:0]  stat_dat_q;
  logic        busy_q;

  logic [43:0] addr_d;
  logic [31:0] wdata_d;

  logic desc_fire, aw_fire, w_fire, b_fire, done_fire, stat_fire, timeout_hit;

  logic unused_inputs;
  assign unused_inputs = ^{m_b_dat[5:2], dma_done_dat};

  // Handshakes are qualified by the registered ready/valid so no input reaches an output combinationally.
  assign desc_fire   = desc_rdy_q & desc_vld;
  assign aw_fire     = m_aw_vld_q & m_aw_rdy;
  assign w_fire      = m_w_vld_q & m_w_rdy;
  assign b_fire      = m_b_rdy_q & m_b_vld;
  assign done_fire   = dma_done_rdy_q & dma_done_vld;
  assign stat_fire   = stat_vld_q & stat_rdy;
  assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (cnt_q == (TIMEOUT_CYCLES - 16'd1));

  always_comb begin
    state_d = state_q;
    ri_d    = ri_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    tag_d   = tag_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (desc_fire) begin
          src_d = desc_dat[31:0];
          dst_d = desc_dat[63:32];
          len_d = desc_dat[95:64];
          tag_d = desc_dat[103:96];
          ri_d  = 2'd0;
          if (desc_dat[95:64] == 32'd0) begin
            code_d  = CODE_SKIP;
            state_d = S_REPORT;
          end else begin
            state_d = S_AW;
          end
        end
      end
      S_AW: if (aw_fire) state_d = S_W;
      S_W:  if (w_fire)  state_d = S_B;
      S_B: begin
        if (b_fire) begin
          if (m_b_dat[1:0] != 2'b00) begin
            code_d  = CODE_BRESP;
            state_d = S_REPORT;
          end else if (ri_q != 2'd3) begin
            ri_d    = ri_q + 2'd1;
            state_d = S_AW;
          end else begin
            cnt_d   = 16'd0;
            state_d = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        // A done arriving on the timeout cycle still counts as success.
        if (done_fire) begin
          code_d  = CODE_OK;
          state_d = S_REPORT;
        end else if (timeout_hit) begin
          code_d  = CODE_TIMEOUT;
          state_d = S_REPORT;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_REPORT: if (stat_fire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = REG_START;
    wdata_d = 32'h1;
    case (ri_d)
      2'd0: begin addr_d = REG_SRC; wdata_d = src_d; end
      2'd1: begin addr_d = REG_DST; wdata_d = dst_d; end
      2'd2: begin addr_d = REG_LEN; wdata_d = len_d; end
      default: begin addr_d = REG_START; wdata_d = 32'h1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q        <= S_IDLE;
      ri_q           <= 2'd0;
      cnt_q          <= 16'd0;
      src_q          <= 32'd0;
      dst_q          <= 32'd0;
      len_q          <= 32'd0;
      tag_q          <= 8'd0;
      code_q         <= 2'd0;
      desc_rdy_q     <= 1'b0;
      m_aw_vld_q     <= 1'b0;
      m_aw_dat_q     <= 44'd0;
      m_w_vld_q      <= 1'b0;
      m_w_dat_q      <= 73'd0;
      m_b_rdy_q      <= 1'b0;
      dma_done_rdy_q <= 1'b0;
      stat_vld_q     <= 1'b0;
      stat_dat_q     <= 10'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ri_q           <= ri_d;
      cnt_q          <= cnt_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      len_q          <= len_d;
      tag_q          <= tag_d;
      code_q         <= code_d;
      desc_rdy_q     <= (state_d == S_IDLE);
      m_aw_vld_q     <= (state_d == S_AW);
      m_aw_dat_q     <= addr_d;
      m_w_vld_q      <= (state_d == S_W);
      m_w_dat_q      <= {8'h00, 1'b1, 32'h0, wdata_d};
      m_b_rdy_q      <= (state_d == S_B);
      dma_done_rdy_q <= (state_d == S_WAIT_DONE);
      stat_vld_q     <= (state_d == S_REPORT);
      stat_dat_q     <= {code_d, tag_d};
      busy_q         <= (state_d != S_IDLE);
    end
  end

  assign desc_rdy     = desc_rdy_q;
  assign m_aw_vld     = m_aw_vld_q;
  assign m_aw_dat     = m_aw_dat_q;
  assign m_w_vld      = m_w_vld_q;
  assign m_w_dat      = m_w_dat_q;
  assign m_b_rdy      = m_b_rdy_q;
  assign dma_done_rdy = dma_done_rdy_q;
  assign stat_vld     = stat_vld_q;
  assign stat_dat     = stat_dat_q;
  assign busy         = busy_q;

endmodule
